data_sram_bridge: RTL

Converts the datapath's single-cycle M-stage data port (mem_enM / mem_wenM / mem_addrM / mem_wdataM / mem_rdataM) into the split-handshake sram-like data bus (req / addr_ok / data_ok) toward the data cache or AXI wrapper. It sits directly downstream of the datapath's memory stage. It raises d_cache_stall while a transaction is outstanding, and buffers the load data so the pipeline can stay frozen for other reasons without losing it.

---
 rtl/data_sram_bridge.sv | 129 ++++++++++++
 1 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: adapts the single-cycle M-stage data port to the split
// req / addr_ok / data_ok sram-like bus. It holds the pipeline with
// d_cache_stall while an access is outstanding. It also buffers load data, so
// the pipeline can stay frozen for other reasons without losing the result.
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic [3:0]  mem_wenM,
  input  logic [31:0] mem_addrM,
  input  logic [31:0] mem_wdataM,
  output logic [31:0] mem_rdataM,
  input  logic        stall_other,
  output logic        d_cache_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        is_store;
  logic [1:0]  size_enc;

  assign is_store = |mem_wenM;

  // Transfer size from the byte enables; anything irregular falls back to a word.
  always_comb begin
    size_enc = 2'd2;
    case (mem_wenM)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_enc = 2'd0;
      4'b0011, 4'b1100:                   size_enc = 2'd1;
      default:                            size_enc = 2'd2;
    endcase
  end

  // Next-state and next request/read-buffer values for the handshake FSM.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    unique case (state_q)
      StIdle: begin
        if (mem_enM) begin
          wr_d    = is_store;
          size_d  = size_enc;
          // Loads always fetch the whole aligned word; the datapath picks the lane.
          addr_d  = is_store ? mem_addrM : {mem_addrM[31:2], 2'b00};
          wdata_d = mem_wdataM;
          state_d = StReq;
        end
      end
      StReq: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            if (!wr_q) rbuf_d = data_rdata;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_data_ok) begin
          if (!wr_q) rbuf_d = data_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        // Leave only when the pipeline advances; the same instruction is still in M otherwise.
        if (!stall_other) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    req_d = (state_d == StReq);
  end

  // State and registered bus outputs; async reset drops data_req immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rbuf_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign data_req      = req_q;
  assign data_wr       = wr_q;
  assign data_size     = size_q;
  assign data_addr     = addr_q;
  assign data_wdata    = wdata_q;
  assign mem_rdataM    = rbuf_q;
  // Combinational so the very first cycle of an access already freezes the pipeline.
  assign d_cache_stall = mem_enM & (state_q != StDone);

endmodule
